// File: rtl/seg_scan_scheduler_if.sv
// rtl/seg_scan_scheduler_if.sv - digit scan control and display bus between counters, scheduler and decoder
interface seg_scan_scheduler_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              digit_code;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    seg_blank;
    logic                    frame_done;
    logic                    load_ack;

    modport master (
        output enable, load, digits_in, blank_mask,
        input  digit_code, digit_sel, seg_blank, frame_done, load_ack
    );

    modport slave (
        input  enable, load, digits_in, blank_mask,
        output digit_code, digit_sel, seg_blank, frame_done, load_ack
    );
endinterface

// File: rtl/seg_scan_scheduler.sv
// rtl/seg_scan_scheduler.sv - multiplexed digit scan scheduler with blanking gaps and frame-synchronous updates
module seg_scan_scheduler #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_CYC  = 250,
    parameter int BLANK_CYC  = 8
) (
    input  logic                clk,
    input  logic                reset,
    seg_scan_scheduler_if.slave bus
);
    localparam int TMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYC - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

    state_t                     state;
    logic [IW-1:0]              idx;
    logic [TW-1:0]              timer;
    logic [NUM_DIGITS-1:0][3:0] shadow;
    logic [NUM_DIGITS-1:0][3:0] pending;
    logic                       pend_v;
    logic [3:0]                 digit_code;
    logic [NUM_DIGITS-1:0]      digit_sel;
    logic                       seg_blank;
    logic                       frame_done;
    logic                       load_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            timer      <= '0;
            shadow     <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            digit_code <= 4'h0;
            digit_sel  <= '0;
            seg_blank  <= 1'b1;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
            // Apply branches below override this capture when load lands on an apply cycle.
            if (bus.load) begin
                pending <= bus.digits_in;
                pend_v  <= 1'b1;
            end
            if (state != ST_IDLE && !bus.enable) begin
                state      <= ST_IDLE;
                idx        <= '0;
                timer      <= '0;
                digit_sel  <= '0;
                seg_blank  <= 1'b1;
                digit_code <= 4'h0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        digit_sel  <= '0;
                        seg_blank  <= 1'b1;
                        digit_code <= 4'h0;
                        if (pend_v) begin
                            shadow   <= bus.load ? bus.digits_in : pending;
                            pend_v   <= 1'b0;
                            load_ack <= 1'b1;
                        end
                        if (bus.enable) begin
                            state <= ST_BLANK;
                            idx   <= '0;
                            timer <= '0;
                        end
                    end
                    ST_BLANK: begin
                        if (timer == BLANK_LAST) begin
                            state      <= ST_SHOW;
                            timer      <= '0;
                            digit_sel  <= NUM_DIGITS'(1) << idx;
                            digit_code <= shadow[idx];
                            seg_blank  <= bus.blank_mask[idx];
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_SHOW: begin
                        seg_blank <= bus.blank_mask[idx];
                        if (timer == DWELL_LAST) begin
                            state      <= ST_BLANK;
                            timer      <= '0;
                            digit_sel  <= '0;
                            seg_blank  <= 1'b1;
                            digit_code <= 4'h0;
                            if (idx == IDX_LAST) begin
                                // Frame boundary: the only point where the visible digits may change.
                                idx        <= '0;
                                frame_done <= 1'b1;
                                if (bus.load || pend_v) begin
                                    shadow   <= bus.load ? bus.digits_in : pending;
                                    pend_v   <= 1'b0;
                                    load_ack <= 1'b1;
                                end
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.digit_code = digit_code;
    assign bus.digit_sel  = digit_sel;
    assign bus.seg_blank  = seg_blank;
    assign bus.frame_done = frame_done;
    assign bus.load_ack   = load_ack;
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb/tb_seg_scan_scheduler.sv - self-checking bench for seg_scan_scheduler against a frame-position model
module tb_seg_scan_scheduler;
    localparam int NUM_DIGITS = 4;
    localparam int DWELL_CYC  = 4;
    localparam int BLANK_CYC  = 2;
    localparam int SLOT       = BLANK_CYC + DWELL_CYC;
    localparam int FRAME      = NUM_DIGITS * SLOT;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    seg_scan_scheduler_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg_scan_scheduler #(
        .NUM_DIGITS(NUM_DIGITS),
        .DWELL_CYC (DWELL_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: position inside the frame is derived from cycles since enable.
    bit          m_run;
    int          m_t;
    logic [15:0] m_shadow, m_pending;
    bit          m_pv;
    bit          m_fd, m_ack, m_care;
    logic [10:0] m_exp;

    function automatic int show_digit();
        int p;
        if (!m_run) return -1;
        p = (m_t - 1) % FRAME;
        if ((p % SLOT) >= BLANK_CYC) return p / SLOT;
        return -1;
    endfunction

    function automatic logic [10:0] dut_vec();
        return {bus.digit_sel, bus.seg_blank, bus.frame_done, bus.load_ack,
                m_care ? bus.digit_code : 4'h0};
    endfunction

    task automatic model_step();
        int         d;
        logic [3:0] sel;
        logic       blk;
        logic [3:0] code;
        m_fd  = 1'b0;
        m_ack = 1'b0;
        if (reset) begin
            m_run = 0; m_t = 0; m_shadow = '0; m_pending = '0; m_pv = 0;
        end else if (!m_run) begin
            if (m_pv) begin
                m_shadow = bus.load ? bus.digits_in : m_pending;
                m_pv = 0; m_ack = 1;
            end else if (bus.load) begin
                m_pending = bus.digits_in; m_pv = 1;
            end
            if (bus.enable) begin m_run = 1; m_t = 1; end
        end else if (!bus.enable) begin
            m_run = 0;
            if (bus.load) begin m_pending = bus.digits_in; m_pv = 1; end
        end else begin
            m_t++;
            if ((m_t - 1) % FRAME == 0) begin
                m_fd = 1;
                if (bus.load || m_pv) begin
                    m_shadow = bus.load ? bus.digits_in : m_pending;
                    m_pv = 0; m_ack = 1;
                end
            end else if (bus.load) begin
                m_pending = bus.digits_in; m_pv = 1;
            end
        end
        sel = 4'h0; blk = 1'b1; code = 4'h0;
        d = show_digit();
        m_care = !m_run || (d >= 0);
        if (d >= 0) begin
            sel  = 4'(1 << d);
            blk  = bus.blank_mask[d];
            code = m_shadow[d*4 +: 4];
        end
        m_exp = {sel, blk, m_fd, m_ack, code};
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0; bus.load = 1'b0; bus.digits_in = '0; bus.blank_mask = '0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (dut_vec() !== 11'b0000_1_0_0_0000) begin
                bad++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 11'b0000_1_0_0_0000);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL idle_hold i=%0d got=%h want=%h", i, dut_vec(), m_exp);
            end
        end
    endtask

    task automatic test_basic_scan();
        int fd_first = -1;
        int fd_second = -1;
        bus.load = 1'b1; bus.digits_in = 16'h4321;
        cycle();
        bus.load = 1'b0;
        cycle();
        total++;
        if (bus.load_ack !== 1'b1) begin
            bad++; $display("FAIL basic_load_ack got=%b want=1", bus.load_ack);
        end
        bus.enable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL basic_scan t=%0d got=%h want=%h", m_t, dut_vec(), m_exp);
            end
            if (bus.frame_done === 1'b1) begin
                if (fd_first < 0) fd_first = m_t;
                else if (fd_second < 0) fd_second = m_t;
            end
        end
        total++;
        if (fd_first !== 25 || fd_second !== 49) begin
            bad++; $display("FAIL basic_frame_done got=%0d,%0d want=25,49", fd_first, fd_second);
        end
    endtask

    task automatic test_deferred_update();
        int phase = 0;
        int acks = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            bus.load = (phase == 0 && show_digit() == 1);
            if (bus.load) begin bus.digits_in = 16'h9876; phase = 1; end
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL deferred t=%0d got=%h want=%h", m_t, dut_vec(), m_exp);
            end
            if (bus.load_ack === 1'b1) begin
                acks++;
                total++;
                if (bus.frame_done !== 1'b1) begin
                    bad++; $display("FAIL deferred_ack_with_fd got=%b want=1", bus.frame_done);
                end
            end
        end
        bus.load = 1'b0;
        total++;
        if (acks !== 1) begin
            bad++; $display("FAIL deferred_ack_count got=%0d want=1", acks);
        end
    endtask

    task automatic test_overwrite();
        int phase = 0;
        int acks = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            bus.load = 1'b0;
            if (phase == 0 && show_digit() == 1) begin
                bus.load = 1'b1; bus.digits_in = 16'h1111; phase = 1;
            end else if (phase == 1 && show_digit() == 2) begin
                bus.load = 1'b1; bus.digits_in = 16'h2222; phase = 2;
            end
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL overwrite t=%0d got=%h want=%h", m_t, dut_vec(), m_exp);
            end
            if (bus.load_ack === 1'b1) acks++;
        end
        bus.load = 1'b0;
        total++;
        if (acks !== 1) begin
            bad++; $display("FAIL overwrite_ack_count got=%0d want=1", acks);
        end
    endtask

    task automatic test_coincide();
        int phase = 0;
        int acks = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            bus.load = (phase == 0 && m_run && (m_t % FRAME) == 0);
            if (bus.load) bus.digits_in = 16'h5555;
            cycle();
            if (bus.load) begin
                phase = 1;
                total++;
                if (bus.load_ack !== 1'b1 || bus.frame_done !== 1'b1) begin
                    bad++; $display("FAIL coincide_ack got=%b%b want=11", bus.load_ack, bus.frame_done);
                end
            end
            bus.load = 1'b0;
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL coincide t=%0d got=%h want=%h", m_t, dut_vec(), m_exp);
            end
            if (bus.load_ack === 1'b1) acks++;
        end
        total++;
        if (acks !== 1) begin
            bad++; $display("FAIL coincide_ack_count got=%0d want=1", acks);
        end
    endtask

    task automatic test_blank_mask();
        bus.blank_mask = 4'b0101;
        for (int k = 0; k < 2 * FRAME; k++) begin
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL blank_mask t=%0d got=%h want=%h", m_t, dut_vec(), m_exp);
            end
        end
        bus.blank_mask = 4'b0000;
    endtask

    task automatic test_abort();
        for (int k = 0; k < 2 * FRAME && show_digit() != 2; k++) begin
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL abort_pre t=%0d got=%h want=%h", m_t, dut_vec(), m_exp);
            end
        end
        bus.enable = 1'b0;
        cycle();
        total++;
        if (bus.digit_sel !== 4'h0 || bus.frame_done !== 1'b0 || bus.seg_blank !== 1'b1) begin
            bad++; $display("FAIL abort_idle got=%h%b%b want=010", bus.digit_sel, bus.seg_blank, bus.frame_done);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL abort_hold k=%0d got=%h want=%h", k, dut_vec(), m_exp);
            end
        end
        bus.enable = 1'b1;
        for (int k = 0; k < FRAME + 4; k++) begin
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL abort_restart t=%0d got=%h want=%h", m_t, dut_vec(), m_exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < FRAME && show_digit() < 0; k++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        total++;
        if (dut_vec() !== 11'b0000_1_0_0_0000) begin
            bad++; $display("FAIL reset_mid got=%h want=%h", dut_vec(), 11'b0000_1_0_0_0000);
        end
        for (int k = 0; k < FRAME + 2; k++) begin
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL reset_mid_scan t=%0d got=%h want=%h", m_t, dut_vec(), m_exp);
            end
            if (show_digit() >= 0) begin
                total++;
                if (bus.digit_code !== 4'h0) begin
                    bad++; $display("FAIL reset_mid_shadow got=%h want=0", bus.digit_code);
                end
            end
        end
    endtask

    task automatic test_random();
        int off_cnt = 0;
        for (int k = 0; k < 900; k++) begin
            bus.load      = ($urandom_range(0, 15) == 0);
            bus.digits_in = 16'($urandom);
            if ($urandom_range(0, 29) == 0) bus.blank_mask = 4'($urandom);
            if (off_cnt > 0) begin
                bus.enable = 1'b0; off_cnt--;
            end else if ($urandom_range(0, 79) == 0) begin
                bus.enable = 1'b0; off_cnt = $urandom_range(0, 4);
            end else begin
                bus.enable = 1'b1;
            end
            cycle();
            total++;
            if (dut_vec() !== m_exp) begin
                bad++; $display("FAIL random k=%0d got=%h want=%h", k, dut_vec(), m_exp);
            end
        end
        bus.load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0; bus.load = 1'b0; bus.digits_in = '0; bus.blank_mask = '0;
        m_run = 0; m_t = 0; m_shadow = '0; m_pending = '0; m_pv = 0;
        m_fd = 0; m_ack = 0; m_care = 1; m_exp = '0;
        test_reset();
        test_basic_scan();
        test_deferred_update();
        test_overwrite();
        test_coincide();
        test_blank_mask();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
